// File: rtl/pwm_pkg.sv
// Shared defaults, reset constants and helpers for the N-channel PWM timer.
// Optional feature macro (see pwm_timer_nch): PWM_POLARITY_EN.
package pwm_pkg;

  localparam int CH_DEF       = 4;
  localparam int BITS_DEF     = 8;
  localparam int PSC_BITS_DEF = 8;

  // All-ones terminal count; callers size-cast down to their counter width.
  localparam logic [31:0] PERIOD_RST = '1;

  // Where the active registers are reloaded from at a wrap.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_STAGE,
    SRC_BYPASS
  } load_src_e;

  // LSB position of channel idx inside a flattened duty bus.
  function automatic int duty_lsb(input int idx, input int bits);
    return idx * bits;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: one tick every prescale+1 enabled cycles.
// prescale is used live; enable low freezes the divider without losing phase.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PSC_BITS = PSC_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PSC_BITS-1:0] prescale,
  output logic                tick
);

  logic [PSC_BITS-1:0] psc_cnt;

  assign tick = enable && (psc_cnt == prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_cnt <= '0;
    end else if (enable) begin
      psc_cnt <= tick ? '0 : psc_cnt + PSC_BITS'(1);
    end
  end

endmodule

// File: rtl/pwm_timer_nch.sv
// N-channel PWM on a shared prescaled counter; period/duty double-buffered, applied at wrap.
// Define PWM_POLARITY_EN to add a per-channel output polarity input buffered the same way.
module pwm_timer_nch
  import pwm_pkg::*;
#(
  parameter int CH       = CH_DEF,
  parameter int BITS     = BITS_DEF,
  parameter int PSC_BITS = PSC_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PSC_BITS-1:0] prescale,
  input  logic [BITS-1:0]     period,
  input  logic [CH*BITS-1:0]  duty_flat,
  input  logic                load,
  output logic                load_ack,
  output logic                period_done,
  output logic [BITS-1:0]     count,
  output logic [CH-1:0]       pwm_out
`ifdef PWM_POLARITY_EN
  ,
  input  logic [CH-1:0]       polarity
`endif
);

  logic                     tick;
  logic                     wrap;
  logic                     pending;
  load_src_e                src;
  logic [BITS-1:0]          period_stg;
  logic [BITS-1:0]          period_act;
  logic [CH-1:0][BITS-1:0]  duty_in;
  logic [CH-1:0][BITS-1:0]  duty_stg;
  logic [CH-1:0][BITS-1:0]  duty_act;
  logic [CH-1:0]            cmp;

  for (genvar i = 0; i < CH; i++) begin : g_duty_in
    assign duty_in[i] = duty_flat[duty_lsb(i, BITS) +: BITS];
  end

  pwm_prescaler #(.PSC_BITS(PSC_BITS)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .prescale (prescale),
    .tick     (tick)
  );

  assign wrap = tick && (count == period_act);

  // A load landing on the wrap cycle wins over older staged values.
  always_comb begin
    src = SRC_NONE;
    if (wrap) begin
      if (load) begin
        src = SRC_BYPASS;
      end else if (pending) begin
        src = SRC_STAGE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= wrap ? '0 : count + BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_stg <= BITS'(PERIOD_RST);
      duty_stg   <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        period_stg <= period;
        duty_stg   <= duty_in;
      end
      if (src != SRC_NONE) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_act <= BITS'(PERIOD_RST);
      duty_act   <= '0;
    end else begin
      case (src)
        SRC_BYPASS: begin
          period_act <= period;
          duty_act   <= duty_in;
        end
        SRC_STAGE: begin
          period_act <= period_stg;
          duty_act   <= duty_stg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_done <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      period_done <= wrap;
      load_ack    <= (src != SRC_NONE);
    end
  end

  // Outputs depend only on registered state, so they cannot glitch on input changes.
  always_comb begin
    cmp = '0;
    for (int i = 0; i < CH; i++) begin
      cmp[i] = (count < duty_act[i]);
    end
  end

`ifdef PWM_POLARITY_EN
  logic [CH-1:0] pol_stg;
  logic [CH-1:0] pol_act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pol_stg <= '0;
      pol_act <= '0;
    end else begin
      if (load) begin
        pol_stg <= polarity;
      end
      case (src)
        SRC_BYPASS: pol_act <= polarity;
        SRC_STAGE:  pol_act <= pol_stg;
        default: ;
      endcase
    end
  end

  assign pwm_out = cmp ^ pol_act;
`else
  assign pwm_out = cmp;
`endif

endmodule

// File: tb/tb_pwm_timer_nch.sv
// Bench for pwm_timer_nch: per-cycle model comparison plus directed literal checks.
module tb_pwm_timer_nch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  prescale = 8'd0;
  logic [7:0]  period = 8'd0;
  logic [31:0] duty_flat = 32'd0;
  logic        load_ack;
  logic        period_done;
  logic [7:0]  count;
  logic [3:0]  pwm_out;
`ifdef PWM_POLARITY_EN
  logic [3:0]  polarity = 4'd0;
`endif

  always #5 clk = ~clk;

  pwm_timer_nch #(.CH(4), .BITS(8), .PSC_BITS(8)) dut (
    .clk         (clk),
    .reset       (rst),
    .enable      (enable),
    .prescale    (prescale),
    .period      (period),
    .duty_flat   (duty_flat),
    .load        (load),
    .load_ack    (load_ack),
    .period_done (period_done),
    .count       (count),
    .pwm_out     (pwm_out)
`ifdef PWM_POLARITY_EN
    ,
    .polarity    (polarity)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: elapsed enabled cycles drive a tick every prescale+1; counter runs 0..period.
  int         m_psc, m_count, m_per, s_per;
  int         m_duty[4];
  int         s_duty[4];
  logic [3:0] m_pol, s_pol;
  bit         m_pend, m_pd, m_ack, tk, wr;
  bit         cmp_on = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_psc = 0; m_count = 0; m_per = 255; m_pend = 0; m_pd = 0; m_ack = 0;
      m_pol = 4'd0; s_pol = 4'd0; s_per = 255;
      for (int i = 0; i < 4; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
    end else begin
      tk = enable && (m_psc == int'(prescale));
      if (enable) m_psc = tk ? 0 : m_psc + 1;
      wr = tk && (m_count == m_per);
      if (tk) m_count = wr ? 0 : m_count + 1;
      m_pd  = wr;
      m_ack = 0;
      if (wr && load) begin
        m_per = int'(period);
        for (int i = 0; i < 4; i++) m_duty[i] = int'(duty_flat[i*8 +: 8]);
`ifdef PWM_POLARITY_EN
        m_pol = polarity;
`endif
        m_ack = 1; m_pend = 0;
      end else if (wr && m_pend) begin
        m_per = s_per;
        for (int i = 0; i < 4; i++) m_duty[i] = s_duty[i];
        m_pol = s_pol;
        m_ack = 1; m_pend = 0;
      end else if (load) begin
        s_per = int'(period);
        for (int i = 0; i < 4; i++) s_duty[i] = int'(duty_flat[i*8 +: 8]);
`ifdef PWM_POLARITY_EN
        s_pol = polarity;
`endif
        m_pend = 1;
      end
    end
  end

  function automatic logic [3:0] exp_pwm();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (m_count < m_duty[i]) ^ m_pol[i];
    return b;
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("mdl_count", count, m_count);
      chk("mdl_pwm", pwm_out, exp_pwm());
      chk("mdl_period_done", period_done, m_pd);
      chk("mdl_load_ack", load_ack, m_ack);
    end
  end

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ack(input string name, input int budget);
    int n = 0;
    while (!load_ack && n < budget) begin @(negedge clk); n++; end
    chk({name, "_ack_seen"}, load_ack, 1);
  endtask

  task automatic wait_count(input string name, input logic [7:0] v);
    int n = 0;
    while (count != v && n < 300) begin @(negedge clk); n++; end
    chk({name, "_reach_count"}, count, v);
  endtask

  int h[4];
  int n_ack, n_pd, n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_period_done", period_done, 0);
    chk("rst_load_ack", load_ack, 0);
    rst = 1'b0; enable = 1'b1; prescale = 8'd0;

    // 1: reset mid-period with a load pending
    repeat (5) @(negedge clk);
    period = 8'd9;
    duty_flat = {8'd12, 8'd9, 8'd3, 8'd0};
    pulse_load();
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_count", count, 0);
    chk("t1_async_pwm", pwm_out, 0);
    @(negedge clk);
    rst = 1'b0;
    n_ack = 0; n_pd = 0;
    repeat (300) begin
      @(negedge clk);
      n_ack += int'(load_ack);
      n_pd  += int'(period_done);
    end
    chk("t1_no_ack", n_ack, 0);
    chk("t1_one_wrap", n_pd, 1);

    // 2: period 9, duties {0,3,9,12}
    pulse_load();
    wait_ack("t2", 300);
    chk("t2_count0", count, 0);
    for (int i = 0; i < 4; i++) h[i] = 0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) h[i] += int'(pwm_out[i]);
      @(negedge clk);
    end
    chk("t2_pd_every_10", period_done, 1);
    chk("t2_ch0_high", h[0], 0);
    chk("t2_ch1_high", h[1], 3);
    chk("t2_ch2_high", h[2], 9);
    chk("t2_ch3_high", h[3], 10);

    // 3: prescale 3, period 4
    prescale = 8'd3;
    period = 8'd4;
    pulse_load();
    wait_ack("t3", 50);
    chk("t3_count0", count, 0);
    repeat (3) @(negedge clk);
    chk("t3_hold", count, 0);
    @(negedge clk);
    chk("t3_tick", count, 1);
    n = 4;
    do begin @(negedge clk); n++; end while (!period_done && n < 60);
    chk("t3_pd_every_20", n, 20);

    // 4: duty change at count 2 applies only at the wrap
    prescale = 8'd0;
    period = 8'd9;
    duty_flat = {8'd12, 8'd9, 8'd3, 8'd0};
    pulse_load();
    wait_ack("t4a", 50);
    @(negedge clk);
    wait_count("t4", 8'd2);
    duty_flat = {8'd12, 8'd9, 8'd6, 8'd0};
    pulse_load();
    chk("t4_old_duty", pwm_out[1], 0);
    wait_ack("t4", 20);
    chk("t4_pd_with_ack", period_done, 1);
    h[1] = 0;
    for (int k = 0; k < 10; k++) begin
      h[1] += int'(pwm_out[1]);
      @(negedge clk);
    end
    chk("t4_new_ch1_high", h[1], 6);

    // 4b: load coincident with wrap bypasses staging
    wait_count("t4b", 8'd9);
    duty_flat = {8'd12, 8'd9, 8'd2, 8'd0};
    pulse_load();
    chk("t4b_ack", load_ack, 1);
    chk("t4b_count0", count, 0);
    chk("t4b_ch1_at0", pwm_out[1], 1);
    repeat (2) @(negedge clk);
    chk("t4b_ch1_at2", pwm_out[1], 0);

    // 5: enable low for 7 cycles at count 5
    wait_count("t5", 8'd5);
    enable = 1'b0;
    repeat (7) begin
      @(negedge clk);
      chk("t5_frozen_count", count, 5);
      chk("t5_frozen_pwm", pwm_out, 4'b1100);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("t5_resume", count, 6);

`ifdef PWM_POLARITY_EN
    // 6: polarity on ch1 takes effect at the next wrap only
    wait_count("t6", 8'd2);
    polarity = 4'b0010;
    pulse_load();
    chk("t6_not_yet", pwm_out, 4'b1100);
    wait_ack("t6", 20);
    chk("t6_inv_at0", pwm_out, 4'b1100);
    repeat (2) @(negedge clk);
    chk("t6_inv_at2", pwm_out, 4'b1110);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
